// File: rtl/edn_pkg.sv
// ---------------------------------------------------------------------------
// edn_pkg
// Shared types and constants for the EDN endpoint interface.
//   edn_req_t       : endpoint -> EDN, level request (held until ack)
//   edn_rsp_t       : EDN -> endpoint, {ack pulse, fips flag, 32-bit chunk}
//   ep_rsp_state_e  : responder FSM states, sparse-encoded so a single
//                     flipped bit never lands on another legal state
// ---------------------------------------------------------------------------
package edn_pkg;

    localparam int ENDPOINT_BUS_WIDTH = 32;
    localparam int GENBITS_BUS_WIDTH  = 128;

    // Number of endpoint chunks carried by one genbits word.
    localparam int CHUNKS_PER_WORD = GENBITS_BUS_WIDTH / ENDPOINT_BUS_WIDTH;

    typedef struct packed {
        logic edn_req;
    } edn_req_t;

    typedef struct packed {
        logic                          edn_ack;
        logic                          edn_fips;
        logic [ENDPOINT_BUS_WIDTH-1:0] edn_bus;
    } edn_rsp_t;

    // Hamming distance between the two encodings is 6.
    typedef enum logic [5:0] {
        EpRspIdle = 6'b011010,
        EpRspAck  = 6'b100101
    } ep_rsp_state_e;

endpackage

// File: rtl/prim_fifo_sync.sv
// ---------------------------------------------------------------------------
// prim_fifo_sync
// Small synchronous FIFO with optional pass-through when empty.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (empties the FIFO next cycle)
//   wvalid_i / wready_o / wdata_i : write handshake
//   rvalid_o / rready_i / rdata_o : read handshake (rdata_o is the head)
//   depth_o       : number of stored entries
// A full FIFO never accepts a write, even if a read happens in the same
// cycle; the freed slot becomes writable on the following cycle.
// ---------------------------------------------------------------------------
module prim_fifo_sync #(
    parameter int unsigned Width  = 16,
    parameter bit          Pass   = 1'b1,
    parameter int unsigned Depth  = 4,
    localparam int unsigned DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  r_storage [Depth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [DepthW-1:0] r_depth;

    logic w_full;
    logic w_empty;
    logic w_pass_through;
    logic w_push;
    logic w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign w_full  = (r_depth == DepthW'(Depth));
    assign w_empty = (r_depth == '0);

    // With Pass set, a word offered to an empty FIFO is visible at the read
    // port immediately; if it is consumed right away it is never stored.
    assign w_pass_through = Pass & w_empty & wvalid_i & rready_i;

    assign wready_o = ~w_full;
    assign rvalid_o = ~w_empty | (Pass & wvalid_i);
    assign rdata_o  = (Pass && w_empty) ? wdata_i : r_storage[r_rptr];
    assign depth_o  = r_depth;

    assign w_push = wvalid_i & ~w_full & ~w_pass_through;
    assign w_pop  = rready_i & ~w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_depth <= '0;
        end else if (clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_depth <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_depth <= r_depth + DepthW'(1);
            end else if (!w_push && w_pop) begin
                r_depth <= r_depth - DepthW'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_storage[r_wptr] <= wdata_i;
        end
    end

endmodule

// File: rtl/edn_ep_responder.sv
// ---------------------------------------------------------------------------
// edn_ep_responder
// Responder end of one EDN endpoint req/ack link. Buffers 128-bit genbits
// words (with their FIPS flag) and hands them out as four 32-bit chunks,
// lowest chunk first, one chunk per single-cycle ack.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   enable_i         : responder enable; low flushes FIFO, FSM and chunk index
//   genbits_valid_i / genbits_ready_o / genbits_bus_i / genbits_fips_i
//                    : upstream word handshake
//   edn_i            : endpoint request (level)
//   edn_o            : registered {ack, fips, bus} response
//   fifo_depth_o     : buffered word count
//   served_cnt_o     : saturating count of acks issued (survives disable)
// ---------------------------------------------------------------------------
module edn_ep_responder
    import edn_pkg::*;
#(
    parameter int unsigned FifoDepth    = 2,
    parameter int unsigned GenBitsWidth = GENBITS_BUS_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    genbits_valid_i,
    output logic                    genbits_ready_o,
    input  logic [GenBitsWidth-1:0] genbits_bus_i,
    input  logic                    genbits_fips_i,
    input  edn_req_t                edn_i,
    output edn_rsp_t                edn_o,
    output logic [2:0]              fifo_depth_o,
    output logic [15:0]             served_cnt_o
);

    localparam int unsigned FifoW  = GenBitsWidth + 1;
    localparam int unsigned DepthW = $clog2(FifoDepth + 1);

    ep_rsp_state_e r_state;
    ep_rsp_state_e w_state_d;

    logic [1:0]                    r_cidx;
    logic                          r_ack;
    logic                          r_fips;
    logic [ENDPOINT_BUS_WIDTH-1:0] r_bus;
    logic [15:0]                   r_served;

    logic                          w_fifo_wready;
    logic                          w_fifo_rvalid;
    logic [FifoW-1:0]              w_fifo_rdata;
    logic [DepthW-1:0]             w_fifo_depth;
    logic                          w_fire;
    logic                          w_pop;
    logic [ENDPOINT_BUS_WIDTH-1:0] w_chunk;
    logic                          w_head_fips;

    // Pass=0: a freshly pushed word is only usable from the next cycle on.
    prim_fifo_sync #(
        .Width (FifoW),
        .Pass  (1'b0),
        .Depth (FifoDepth)
    ) u_word_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (~enable_i),
        .wvalid_i (genbits_valid_i & enable_i),
        .wready_o (w_fifo_wready),
        .wdata_i  ({genbits_fips_i, genbits_bus_i}),
        .rvalid_o (w_fifo_rvalid),
        .rready_i (w_pop),
        .rdata_o  (w_fifo_rdata),
        .depth_o  (w_fifo_depth)
    );

    assign genbits_ready_o = enable_i & w_fifo_wready;

    assign w_chunk     = w_fifo_rdata[ENDPOINT_BUS_WIDTH*r_cidx +: ENDPOINT_BUS_WIDTH];
    assign w_head_fips = w_fifo_rdata[GenBitsWidth];

    // An ack is launched only from Idle, which forces a gap cycle between
    // consecutive acks; a request still held after an ack is a new request.
    assign w_fire = (r_state == EpRspIdle) & enable_i & edn_i.edn_req & w_fifo_rvalid;

    // The head word retires together with the ack that hands out chunk 3.
    assign w_pop = w_fire & (r_cidx == 2'd3);

    always_comb begin
        w_state_d = r_state;
        if (!enable_i) begin
            w_state_d = EpRspIdle;
        end else begin
            case (r_state)
                EpRspIdle: if (w_fire) w_state_d = EpRspAck;
                EpRspAck:  w_state_d = EpRspIdle;
                default:   w_state_d = EpRspIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= EpRspIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Response register: bus/fips keep their last value after the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack  <= 1'b0;
            r_fips <= 1'b0;
            r_bus  <= '0;
            r_cidx <= '0;
        end else if (!enable_i) begin
            r_ack  <= 1'b0;
            r_cidx <= '0;
        end else begin
            r_ack <= w_fire;
            if (w_fire) begin
                r_bus  <= w_chunk;
                r_fips <= w_head_fips;
                r_cidx <= r_cidx + 2'd1;
            end
        end
    end

    // Status counter is deliberately not cleared by disable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_served <= '0;
        end else if (w_fire && (r_served != 16'hFFFF)) begin
            r_served <= r_served + 16'd1;
        end
    end

    assign edn_o.edn_ack  = r_ack;
    assign edn_o.edn_fips = r_fips;
    assign edn_o.edn_bus  = r_bus;
    assign fifo_depth_o   = 3'(w_fifo_depth);
    assign served_cnt_o   = r_served;

endmodule
